// File: rtl/sphere_pair_fetch_pkg.sv
// Shared definitions for the sphere pair fetch stage: record layout and FSM states.
package sphere_fetch_pkg;

    localparam int unsigned SPHERE_WORDS = 5;

    typedef logic [2:0] off_t;

    localparam off_t OFF_X = 3'd0;
    localparam off_t OFF_Y = 3'd1;
    localparam off_t OFF_Z = 3'd2;
    localparam off_t OFF_R = 3'd3;
    localparam off_t OFF_G = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_DRAIN,
        ST_PRESENT,
        ST_FINISH
    } state_t;

endpackage

// File: rtl/sphere_pair_fetch_if.sv
// Control, memory-read and pair-output bundle between the fetch stage and its environment.
interface sphere_pair_fetch_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned IDX_W  = 8
) ();

    logic                 start;
    logic [IDX_W-1:0]     num_spheres;
    logic [ADDR_W-1:0]    base_addr;

    logic                 mem_rd_en;
    logic [ADDR_W-1:0]    mem_addr;
    logic [31:0]          mem_rdata;

    logic [31:0]          x1, y1, z1, r1, g1;
    logic [31:0]          x2, y2, z2, r2, g2;
    logic [IDX_W-1:0]     pair_i;
    logic [IDX_W-1:0]     pair_j;
    logic                 out_valid;
    logic                 out_ready;

    logic                 busy;
    logic                 done;
    logic [2*IDX_W-1:0]   pair_count;

    modport master (
        input  start, num_spheres, base_addr, mem_rdata, out_ready,
        output mem_rd_en, mem_addr,
        output x1, y1, z1, r1, g1, x2, y2, z2, r2, g2,
        output pair_i, pair_j, out_valid, busy, done, pair_count
    );

    modport slave (
        output start, num_spheres, base_addr, mem_rdata, out_ready,
        input  mem_rd_en, mem_addr,
        input  x1, y1, z1, r1, g1, x2, y2, z2, r2, g2,
        input  pair_i, pair_j, out_valid, busy, done, pair_count
    );

endinterface

// File: rtl/sphere_pair_fetch_word_capture.sv
// One sphere slot: remembers which offset was read last cycle and latches the returning word.
module sphere_word_capture
    import sphere_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_cap_en,
    input  off_t        i_off,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_x,
    output logic [31:0] o_y,
    output logic [31:0] o_z,
    output logic [31:0] o_r,
    output logic [31:0] o_g
);

    logic        r_tag_vld;
    off_t        r_tag_off;
    logic [31:0] r_words [SPHERE_WORDS];

    // Read data lags the strobe by one cycle, so the offset tag is delayed to match.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_vld <= 1'b0;
            r_tag_off <= OFF_X;
            for (int unsigned k = 0; k < SPHERE_WORDS; k++) begin
                r_words[k] <= '0;
            end
        end else begin
            r_tag_vld <= i_cap_en;
            r_tag_off <= i_off;
            if (r_tag_vld) begin
                r_words[r_tag_off] <= i_rdata;
            end
        end
    end

    assign o_x = r_words[OFF_X];
    assign o_y = r_words[OFF_Y];
    assign o_z = r_words[OFF_Z];
    assign o_r = r_words[OFF_R];
    assign o_g = r_words[OFF_G];

endmodule

// File: rtl/sphere_pair_fetch.sv
// Walks all unordered sphere pairs (i<j) of a table in memory and presents each pair on valid/ready.
module sphere_pair_fetch
    import sphere_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned IDX_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    sphere_pair_fetch_if.master  bus
);

    localparam int unsigned CW = IDX_W + 1;
    localparam int unsigned PW = 2 * IDX_W;

    state_t              r_state;
    state_t              w_state_nxt;
    off_t                r_off;
    logic [IDX_W-1:0]    r_n;
    logic [ADDR_W-1:0]   r_base;
    logic [IDX_W-1:0]    r_i;
    logic [IDX_W-1:0]    r_j;
    logic [PW-1:0]       r_cnt;

    logic                w_rd_en;
    logic                w_valid;
    logic                w_busy;
    logic                w_done;
    logic                w_xfer;
    logic                w_j_more;
    logic                w_i_more;
    logic [IDX_W-1:0]    w_rd_idx;
    logic [ADDR_W-1:0]   w_rd_addr;

    // Compare in one extra bit so i+2 / j+1 cannot wrap for large N.
    assign w_j_more = ({1'b0, r_j} + CW'(1)) < {1'b0, r_n};
    assign w_i_more = ({1'b0, r_i} + CW'(2)) < {1'b0, r_n};
    assign w_xfer   = (r_state == ST_PRESENT) && bus.out_ready;

    assign w_rd_idx  = (r_state == ST_LOAD_A) ? r_i : r_j;
    assign w_rd_addr = r_base + ADDR_W'(w_rd_idx) * ADDR_W'(SPHERE_WORDS) + ADDR_W'(r_off);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_valid     = 1'b0;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_state_nxt = (bus.num_spheres < IDX_W'(2)) ? ST_FINISH : ST_LOAD_A;
                end
            end
            ST_LOAD_A: begin
                w_rd_en = 1'b1;
                if (r_off == OFF_G) begin
                    w_state_nxt = ST_LOAD_B;
                end
            end
            ST_LOAD_B: begin
                w_rd_en = 1'b1;
                if (r_off == OFF_G) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_state_nxt = ST_PRESENT;
            end
            ST_PRESENT: begin
                w_valid = 1'b1;
                if (bus.out_ready) begin
                    if (w_j_more) begin
                        w_state_nxt = ST_LOAD_B;
                    end else if (w_i_more) begin
                        w_state_nxt = ST_LOAD_A;
                    end else begin
                        w_state_nxt = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_off <= OFF_X;
        end else if (r_state == ST_LOAD_A || r_state == ST_LOAD_B) begin
            r_off <= (r_off == OFF_G) ? OFF_X : r_off + 3'd1;
        end else begin
            r_off <= OFF_X;
        end
    end

    // Sweep parameters are captured only on an accepted start, so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_n    <= '0;
            r_base <= '0;
            r_i    <= '0;
            r_j    <= '0;
            r_cnt  <= '0;
        end else if (r_state == ST_IDLE && bus.start) begin
            r_n    <= bus.num_spheres;
            r_base <= bus.base_addr;
            r_i    <= '0;
            r_j    <= IDX_W'(1);
            r_cnt  <= '0;
        end else if (w_xfer) begin
            r_cnt <= r_cnt + PW'(1);
            if (w_j_more) begin
                r_j <= r_j + IDX_W'(1);
            end else if (w_i_more) begin
                r_i <= r_i + IDX_W'(1);
                r_j <= r_i + IDX_W'(2);
            end
        end
    end

    sphere_word_capture u_slot_a (
        .clk      (clk),
        .rst      (rst),
        .i_cap_en (r_state == ST_LOAD_A),
        .i_off    (r_off),
        .i_rdata  (bus.mem_rdata),
        .o_x      (bus.x1),
        .o_y      (bus.y1),
        .o_z      (bus.z1),
        .o_r      (bus.r1),
        .o_g      (bus.g1)
    );

    sphere_word_capture u_slot_b (
        .clk      (clk),
        .rst      (rst),
        .i_cap_en (r_state == ST_LOAD_B),
        .i_off    (r_off),
        .i_rdata  (bus.mem_rdata),
        .o_x      (bus.x2),
        .o_y      (bus.y2),
        .o_z      (bus.z2),
        .o_r      (bus.r2),
        .o_g      (bus.g2)
    );

    assign bus.mem_rd_en  = w_rd_en;
    assign bus.mem_addr   = w_rd_en ? w_rd_addr : '0;
    assign bus.out_valid  = w_valid;
    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.pair_i     = r_i;
    assign bus.pair_j     = r_j;
    assign bus.pair_count = r_cnt;

endmodule

// File: tb/tb_sphere_pair_fetch.sv
// Randomised bench for sphere_pair_fetch against a pair-list / address-list reference model.
module tb_sphere_pair_fetch;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned IDX_W  = 8;
    localparam int unsigned MEM_SZ = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sphere_pair_fetch_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) bus ();

    sphere_pair_fetch #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] mem [0:MEM_SZ-1];
    always @(posedge clk) begin
        if (bus.mem_rd_en === 1'b1) bus.mem_rdata <= mem[bus.mem_addr];
    end

    int unsigned rd_cnt = 0;
    int unsigned rd_q[$];
    always @(negedge clk) begin
        if (bus.mem_rd_en === 1'b1) begin
            rd_cnt++;
            rd_q.push_back(int'(bus.mem_addr));
        end
    end

    function automatic logic [31:0] exp_word(input int unsigned base, input int unsigned idx,
                                             input int unsigned off);
        return mem[(base + idx * 5 + off) % MEM_SZ];
    endfunction

    function automatic logic [335:0] exp_pair(input int unsigned base, input int unsigned i,
                                              input int unsigned j);
        logic [7:0] ii, jj;
        ii = i[7:0];
        jj = j[7:0];
        return {exp_word(base, i, 0), exp_word(base, i, 1), exp_word(base, i, 2),
                exp_word(base, i, 3), exp_word(base, i, 4),
                exp_word(base, j, 0), exp_word(base, j, 1), exp_word(base, j, 2),
                exp_word(base, j, 3), exp_word(base, j, 4), ii, jj};
    endfunction

    function automatic logic [335:0] got_pair();
        return {bus.x1, bus.y1, bus.z1, bus.r1, bus.g1,
                bus.x2, bus.y2, bus.z2, bus.r2, bus.g2, bus.pair_i, bus.pair_j};
    endfunction

    function automatic logic [368:0] got_all();
        return {bus.out_valid, bus.busy, bus.done, bus.mem_rd_en, bus.mem_addr,
                bus.pair_count, got_pair()};
    endfunction

    task automatic fill_pattern(input int unsigned base);
        for (int k = 0; k < 8; k++)
            for (int o = 0; o < 5; o++)
                mem[(base + k * 5 + o) % MEM_SZ] = k * 16 + o;
    endtask

    task automatic fill_random();
        for (int a = 0; a < MEM_SZ; a++) mem[a] = $urandom;
    endtask

    // Runs one sweep and scores every presented pair, the read address stream and the end-of-sweep state.
    task automatic run_sweep(input int unsigned n, input int unsigned base,
                             input int unsigned ready_pct, input bit poke, input string name);
        int unsigned ei[$], ej[$], exp_addr[$];
        int unsigned xfers = 0, dones = 0, cyc = 0, since_xfer = 1000;
        int unsigned total;
        bit finished = 0;
        bit addr_ok;
        logic [335:0] got, exp;
        for (int a = 0; a < int'(n); a++)
            for (int b = a + 1; b < int'(n); b++) begin
                ei.push_back(a);
                ej.push_back(b);
            end
        total = ei.size();
        for (int p = 0; p < int'(total); p++) begin
            if (p == 0 || ei[p] != ei[p-1])
                for (int o = 0; o < 5; o++) exp_addr.push_back((base + ei[p] * 5 + o) % MEM_SZ);
            for (int o = 0; o < 5; o++) exp_addr.push_back((base + ej[p] * 5 + o) % MEM_SZ);
        end
        rd_q.delete();
        bus.num_spheres = n[IDX_W-1:0];
        bus.base_addr   = base[ADDR_W-1:0];
        bus.start       = 1'b1;
        bus.out_ready   = 1'b0;
        while (!finished && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            since_xfer++;
            bus.start       = 1'b0;
            bus.num_spheres = IDX_W'($urandom);
            bus.base_addr   = ADDR_W'($urandom);
            if (poke && (cyc == 3 || cyc == 14)) bus.start = 1'b1;
            if (bus.done === 1'b1) begin
                dones++;
                finished = 1;
                if (n >= 2) begin
                    tests_run++;
                    if (since_xfer !== 1) begin
                        tests_failed++;
                        $display("FAIL %s done_latency: got %0d cycles after last transfer, want 1",
                                 name, since_xfer);
                    end
                end
            end
            if (bus.out_valid === 1'b1) begin
                tests_run++;
                if (ei.size() == 0) begin
                    tests_failed++;
                    $display("FAIL %s extra_pair: got i=%0d j=%0d, want no pair", name,
                             bus.pair_i, bus.pair_j);
                end else begin
                    got = got_pair();
                    exp = exp_pair(base, ei[0], ej[0]);
                    if (got !== exp) begin
                        tests_failed++;
                        $display("FAIL %s pair(%0d,%0d): got %h want %h", name, ei[0], ej[0],
                                 got, exp);
                    end
                end
                if ($urandom_range(99) < ready_pct) begin
                    bus.out_ready = 1'b1;
                    if (ei.size() != 0) begin
                        void'(ei.pop_front());
                        void'(ej.pop_front());
                    end
                    xfers++;
                    since_xfer = 0;
                end else begin
                    bus.out_ready = 1'b0;
                end
            end else begin
                bus.out_ready = 1'($urandom_range(1));
            end
        end
        bus.out_ready = 1'b0;
        tests_run++;
        if (!finished) begin
            tests_failed++;
            $display("FAIL %s timeout: got no done in %0d cycles, want done", name, cyc);
        end
        @(negedge clk);
        tests_run++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s post_done: got busy=%b done=%b, want 0 0", name, bus.busy, bus.done);
        end
        tests_run++;
        if (bus.pair_count !== 16'(total) || xfers != total || dones != 1) begin
            tests_failed++;
            $display("FAIL %s counts: got pair_count=%0d xfers=%0d dones=%0d, want %0d %0d 1",
                     name, bus.pair_count, xfers, dones, total, total);
        end
        addr_ok = (rd_q.size() == exp_addr.size());
        if (addr_ok)
            foreach (rd_q[k]) if (rd_q[k] != exp_addr[k]) addr_ok = 0;
        tests_run++;
        if (!addr_ok) begin
            tests_failed++;
            $display("FAIL %s read_addrs: got %0d reads (first %0d), want %0d reads (first %0d)",
                     name, rd_q.size(), rd_q.size() ? rd_q[0] : 0, exp_addr.size(),
                     exp_addr.size() ? exp_addr[0] : 0);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.out_ready = 1'b0; bus.num_spheres = '0; bus.base_addr = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (got_all() !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h, want all zero", got_all());
        end
        bus.start = 1'b1; bus.num_spheres = 8'd3;
        @(negedge clk);
        bus.start = 1'b0; rst = 1'b0;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.mem_rd_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_vs_start: got busy=%b rd=%b, want 0 0", bus.busy, bus.mem_rd_en);
        end
        @(negedge clk);
        tests_run++;
        if (bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_vs_start_late: got busy=%b, want 0", bus.busy);
        end
    endtask

    task automatic test_pattern();
        fill_pattern(32'h10);
        run_sweep(3, 32'h10, 100, 0, "pattern_n3");
        tests_run++;
        if (bus.x1 !== 32'h10 || bus.g2 !== 32'h24 || bus.pair_i !== 8'd1 || bus.pair_j !== 8'd2) begin
            tests_failed++;
            $display("FAIL pattern_last: got x1=%h g2=%h i=%0d j=%0d, want 10 24 1 2",
                     bus.x1, bus.g2, bus.pair_i, bus.pair_j);
        end
    endtask

    task automatic test_latency_n2();
        int first_rd = 0, first_val = 0, xfer_c = 0, done_c = 0;
        int unsigned r0;
        fill_random();
        r0 = rd_cnt;
        bus.num_spheres = 8'd2; bus.base_addr = 10'h040; bus.start = 1'b1; bus.out_ready = 1'b1;
        for (int k = 1; k <= 40 && done_c == 0; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.mem_rd_en === 1'b1 && first_rd == 0) first_rd = k;
            if (bus.out_valid === 1'b1 && first_val == 0) begin
                first_val = k;
                xfer_c = k;
            end
            if (bus.done === 1'b1) done_c = k;
        end
        bus.out_ready = 1'b0;
        tests_run++;
        if (first_rd != 1 || rd_cnt - r0 != 10) begin
            tests_failed++;
            $display("FAIL n2_reads: got first=%0d count=%0d, want 1 10", first_rd, rd_cnt - r0);
        end
        tests_run++;
        if (first_val != 12) begin
            tests_failed++;
            $display("FAIL n2_valid_cycle: got %0d, want 12", first_val);
        end
        tests_run++;
        if (done_c != 13 || done_c != xfer_c + 1) begin
            tests_failed++;
            $display("FAIL n2_done_cycle: got %0d, want 13", done_c);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [335:0] snap;
        int unsigned r0;
        int k = 0;
        bit stable = 1;
        fill_pattern(32'h10);
        bus.num_spheres = 8'd3; bus.base_addr = 10'h010; bus.start = 1'b1; bus.out_ready = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        while (bus.out_valid !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        snap = got_pair();
        r0 = rd_cnt;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || got_pair() !== snap) stable = 0;
        end
        tests_run++;
        if (!stable || snap !== exp_pair(32'h10, 0, 1)) begin
            tests_failed++;
            $display("FAIL bp_stable: got %h, want %h held with valid", got_pair(), exp_pair(32'h10, 0, 1));
        end
        tests_run++;
        if (rd_cnt != r0) begin
            tests_failed++;
            $display("FAIL bp_no_reads: got %0d reads, want 0", rd_cnt - r0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        k = 1;
        while (bus.out_valid !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        tests_run++;
        if (k != 7 || bus.pair_j !== 8'd2) begin
            tests_failed++;
            $display("FAIL bp_next_valid: got %0d cycles j=%0d, want 7 j=2", k, bus.pair_j);
        end
        bus.out_ready = 1'b1;
        k = 0;
        while (bus.done !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        bus.out_ready = 1'b0;
        tests_run++;
        if (bus.done !== 1'b1 || bus.pair_count !== 16'd3) begin
            tests_failed++;
            $display("FAIL bp_finish: got done=%b count=%0d, want 1 3", bus.done, bus.pair_count);
        end
        @(negedge clk);
    endtask

    task automatic test_small_n();
        int unsigned r0;
        for (int n = 0; n < 2; n++) begin
            r0 = rd_cnt;
            bus.num_spheres = IDX_W'(n); bus.base_addr = 10'h100; bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            tests_run++;
            if (bus.done !== 1'b1 || bus.pair_count !== '0) begin
                tests_failed++;
                $display("FAIL small_n%0d_done: got done=%b count=%0d, want 1 0", n, bus.done,
                         bus.pair_count);
            end
            @(negedge clk);
            tests_run++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL small_n%0d_after: got done=%b busy=%b, want 0 0", n, bus.done, bus.busy);
            end
            repeat (3) @(negedge clk);
            tests_run++;
            if (rd_cnt != r0) begin
                tests_failed++;
                $display("FAIL small_n%0d_reads: got %0d, want 0", n, rd_cnt - r0);
            end
        end
    endtask

    task automatic test_wrap();
        fill_random();
        run_sweep(2, MEM_SZ - 3, 60, 1, "wrap");
        tests_run++;
        if (rd_q.size() != 10 || rd_q[3] != 0 || rd_q[9] != 6) begin
            tests_failed++;
            $display("FAIL wrap_addrs: got size=%0d a3=%0d a9=%0d, want 10 0 6", rd_q.size(),
                     rd_q.size() > 3 ? rd_q[3] : 0, rd_q.size() > 9 ? rd_q[9] : 0);
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        bit no_done = 1;
        fill_pattern(32'h10);
        bus.num_spheres = 8'd3; bus.base_addr = 10'h010; bus.start = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (bus.out_valid !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.mem_rd_en !== 1'b1 || bus.pair_j !== 8'd2) begin
            tests_failed++;
            $display("FAIL rstmid_setup: got rd=%b j=%0d, want 1 2", bus.mem_rd_en, bus.pair_j);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if (got_all() !== '0) begin
            tests_failed++;
            $display("FAIL rstmid_outputs: got %h, want all zero", got_all());
        end
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) no_done = 0;
        end
        tests_run++;
        if (!no_done) begin
            tests_failed++;
            $display("FAIL rstmid_idle: got done/busy activity, want none");
        end
        run_sweep(3, 32'h10, 100, 0, "post_reset");
    endtask

    task automatic test_random();
        int unsigned n, base;
        for (int t = 0; t < 6; t++) begin
            fill_random();
            n    = $urandom_range(2, 7);
            base = $urandom_range(0, MEM_SZ - 1);
            run_sweep(n, base, $urandom_range(30, 100), 1, $sformatf("random%0d", t));
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.out_ready = 1'b0; bus.num_spheres = '0; bus.base_addr = '0;
        test_reset();
        test_pattern();
        test_latency_n2();
        test_backpressure();
        test_small_n();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
